// File: rtl/branch_offset_pack.sv
// -----------------------------------------------------------------------------
// branch_offset_pack
//
// Purpose
//   Turns a (branch pc, branch target) address pair into the packed signed
//   word offset held in a branch instruction's immediate field. This is the
//   inverse of the decode-side step that sign-extends the immediate and
//   shifts it left by 2: re-expanding imm gives back target - pc whenever
//   neither flag is set.
//
//   diff = target - pc        (64-bit, wraps modulo 2^64)
//   imm  = diff[OFF_W+1:2]
//   out_of_range = diff[63:OFF_W+1] are not all equal
//   misaligned   = diff[1:0] != 0   (only when the alignment check is built in)
//
//   Both flags are independent of each other. imm is driven from diff even
//   when one or both flags are set.
//
// Pipeline
//   S1 registers diff. S2 registers imm and both flags.
//   Valid/ready handshakes are used at both ends. With out_ready held high,
//   a request accepted on one edge is presented on out_valid after the next
//   edge, so the result appears 2 cycles after the request is offered, and
//   one result can be produced per cycle. Under backpressure the two stages
//   hold at most two requests. in_ready then drops, and nothing is lost or
//   duplicated.
//
// Configuration
//   BRANCH_OFFSET_ALIGN_CHECK_EN : when defined, misaligned reports
//   diff[1:0] != 0 and is registered in S2. When undefined, misaligned is
//   tied to 0 and the low two bits of diff are never formed.
//
// Parameters
//   OFF_W        width of the signed word-offset field (default 26, sane 2..61)
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset_n      asynchronous active-low reset; clears both stages
//   in_valid     request present
//   in_ready     block accepts a request this cycle (no path from in_valid)
//   pc           branch instruction address
//   target       branch destination address
//   out_valid    result present
//   out_ready    consumer accepts the result this cycle
//   imm          packed signed word offset
//   out_of_range offset does not fit in OFF_W signed bits
//   misaligned   byte offset is not a multiple of 4
// -----------------------------------------------------------------------------
module branch_offset_pack #(
  parameter int OFF_W = 26
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      pc,
  input  logic [63:0]      target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OFF_W-1:0] imm,
  output logic             out_of_range,
  output logic             misaligned
);

  // diff[63:2] is kept as a 62-bit word. Bit k of diff is bit k-2 here.
  localparam int HI_W = 62;

  // ---------------------------------------------------------------------------
  // Subtractor
  // The upper 62 bits are computed on their own. A borrow is taken when the
  // low two bits of target are smaller than those of pc. This gives
  // diff[63:2] exactly, without building diff[1:0] in builds that ignore it.
  // ---------------------------------------------------------------------------
  logic            lo_borrow;
  logic [HI_W-1:0] diff_hi;

  assign lo_borrow = (target[1:0] < pc[1:0]);
  assign diff_hi   = target[63:2] - pc[63:2] - {{(HI_W-1){1'b0}}, lo_borrow};

  // ---------------------------------------------------------------------------
  // Handshake / stage control
  // ---------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_load;
  logic s1_accept;

  // S2 can take a new value when it is empty or is being drained this edge.
  assign s2_load   = !s2_valid_q || out_ready;
  // S1 can take a new request when it is empty, or when it moves into S2 on
  // the same edge. This depends only on state and out_ready.
  assign in_ready  = !s1_valid_q || s2_load;
  assign s1_accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // S1: registered diff
  // ---------------------------------------------------------------------------
  logic [HI_W-1:0] s1_diff_hi_q, s1_diff_hi_d;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_diff_hi_d = s1_diff_hi_q;
    // If S1 is open, it holds exactly what is offered this cycle. If nothing
    // is offered, the entry that moved into S2 leaves S1 empty.
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (s1_accept) begin
      s1_diff_hi_d = diff_hi;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q   <= 1'b0;
      s1_diff_hi_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_diff_hi_q <= s1_diff_hi_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S2 datapath terms, formed from the S1 register
  // ---------------------------------------------------------------------------
  logic [HI_W-OFF_W:0] s1_upper;   // diff[63:OFF_W+1]
  logic                oor_calc;
  logic [OFF_W-1:0]    imm_calc;   // diff[OFF_W+1:2]

  assign s1_upper = s1_diff_hi_q[HI_W-1:OFF_W-1];
  assign imm_calc = s1_diff_hi_q[OFF_W-1:0];
  // The offset fits only if every bit above the field repeats its sign bit.
  assign oor_calc = !((&s1_upper) || (~|s1_upper));

  // ---------------------------------------------------------------------------
  // S2: registered imm and flags
  // ---------------------------------------------------------------------------
  logic [OFF_W-1:0] imm_q, imm_d;
  logic             oor_q, oor_d;

  always_comb begin
    s2_valid_d = s2_valid_q;
    imm_d      = imm_q;
    oor_d      = oor_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      // The payload is only updated when a real entry arrives. When the
      // pipe drains, the last result stays on imm instead of S1 leftovers.
      if (s1_valid_q) begin
        imm_d = imm_calc;
        oor_d = oor_calc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q <= 1'b0;
      imm_q      <= '0;
      oor_q      <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      imm_q      <= imm_d;
      oor_q      <= oor_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign imm          = imm_q;
  assign out_of_range = oor_q;

  // ---------------------------------------------------------------------------
  // Optional alignment check
  // ---------------------------------------------------------------------------
`ifdef BRANCH_OFFSET_ALIGN_CHECK_EN
  logic [1:0] diff_lo;
  logic [1:0] s1_diff_lo_q, s1_diff_lo_d;
  logic       mis_q, mis_d;

  // Low two bits of target - pc. Together with diff_hi, this is the full diff.
  assign diff_lo = target[1:0] - pc[1:0];

  always_comb begin
    s1_diff_lo_d = s1_diff_lo_q;
    if (s1_accept) begin
      s1_diff_lo_d = diff_lo;
    end
  end

  always_comb begin
    mis_d = mis_q;
    if (s2_load && s1_valid_q) begin
      mis_d = |s1_diff_lo_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_diff_lo_q <= 2'b00;
      mis_q        <= 1'b0;
    end else begin
      s1_diff_lo_q <= s1_diff_lo_d;
      mis_q        <= mis_d;
    end
  end

  assign misaligned = mis_q;
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_branch_offset_pack.sv
// -----------------------------------------------------------------------------
// tb_branch_offset_pack
//
// Directed and random stimulus for branch_offset_pack. Expected results come
// from a scoreboard queue. Entries are either constants from the worked
// examples, or values from a plain-arithmetic model: signed difference,
// arithmetic shift, range compare and modulo.
// -----------------------------------------------------------------------------
module tb_branch_offset_pack;

  localparam int OFF_W = 26;
`ifdef BRANCH_OFFSET_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic             clk       = 1'b0;
  logic             reset_n   = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic [63:0]      pc        = '0;
  logic [63:0]      target    = '0;
  logic             in_ready;
  logic             out_valid;
  logic [OFF_W-1:0] imm;
  logic             out_of_range;
  logic             misaligned;

  branch_offset_pack #(.OFF_W(OFF_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pc           (pc),
    .target       (target),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .imm          (imm),
    .out_of_range (out_of_range),
    .misaligned   (misaligned)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OFF_W-1:0] imm;
    logic             oor;
    logic             mis;
  } res_t;

  res_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   use_const = 1'b0;
  res_t const_exp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: signed byte distance, arithmetic shift to words, and a
  // range test on the signed value.
  function automatic res_t model(input logic [63:0] p, input logic [63:0] t);
    res_t   r;
    longint sd;
    longint lim;
    sd    = longint'(t - p);
    lim   = longint'(1) <<< (OFF_W + 1);
    r.imm = OFF_W'(sd >>> 2);
    r.oor = (sd < -lim) || (sd >= lim);
    r.mis = ALIGN && (((t - p) % 64'd4) != 64'd0);
    return r;
  endfunction

  // One clock cycle. Inputs must be driven before this task is called.
  // Handshakes are sampled mid-cycle, then the bench waits for the edge.
  task automatic cycle(output bit acc);
    bit   drn;
    bit   hold;
    res_t seen;
    res_t e;
    #2;
    acc       = in_valid && in_ready;
    drn       = out_valid && out_ready;
    hold      = out_valid && !out_ready;
    seen.imm  = imm;
    seen.oor  = out_of_range;
    seen.mis  = misaligned;
    if (drn) begin
      chk("result_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("result imm=%h oor=%b mis=%b", seen.imm, seen.oor, seen.mis);
        chk("imm", 64'(seen.imm), 64'(e.imm));
        chk("out_of_range", 64'(seen.oor), 64'(e.oor));
        chk("misaligned", 64'(seen.mis), 64'(e.mis));
      end
    end
    if (acc) begin
      exp_q.push_back(use_const ? const_exp : model(pc, target));
      $display("accept pc=%h target=%h", pc, target);
    end
    @(posedge clk);
    #1;
    if (hold) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_imm", 64'(imm), 64'(seen.imm));
      chk("hold_oor", 64'(out_of_range), 64'(seen.oor));
      chk("hold_mis", 64'(misaligned), 64'(seen.mis));
    end
  endtask

  task automatic send(input logic [63:0] p, input logic [63:0] t);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    pc       = p;
    target   = t;
    for (int i = 0; i < 50 && !acc; i++) cycle(acc);
    in_valid = 1'b0;
    chk("send_accepted", 64'(acc), 64'd1);
  endtask

  task automatic send_const(input logic [63:0] p, input logic [63:0] t,
                            input logic [OFF_W-1:0] ei, input logic eo, input logic em);
    const_exp.imm = ei;
    const_exp.oor = eo;
    const_exp.mis = em;
    use_const     = 1'b1;
    send(p, t);
    use_const     = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycle(acc);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bit acc;
    int n_acc;
    int idx;

    // ---- reset state ----
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_imm", 64'(imm), 64'd0);
    chk("rst_oor", 64'(out_of_range), 64'd0);
    chk("rst_mis", 64'(misaligned), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // ---- basic case and latency ----
    out_ready     = 1'b1;
    in_valid      = 1'b1;
    pc            = 64'h1000;
    target        = 64'h1010;
    const_exp.imm = 26'h0000004;
    const_exp.oor = 1'b0;
    const_exp.mis = 1'b0;
    use_const     = 1'b1;
    cycle(acc);
    use_const     = 1'b0;
    in_valid      = 1'b0;
    chk("basic_accept", 64'(acc), 64'd1);
    chk("lat1_out_valid", 64'(out_valid), 64'd0);
    cycle(acc);
    chk("lat2_out_valid", 64'(out_valid), 64'd1);
    chk("lat2_imm", 64'(imm), 64'h4);
    drain();

    // ---- boundaries, wrap, alignment (back to back) ----
    out_ready = 1'b1;
    send_const(64'h2000, 64'h1000, 26'h3FFFC00, 1'b0, 1'b0);
    send_const(64'h0, 64'h7FFFFFC, 26'h1FFFFFF, 1'b0, 1'b0);
    send_const(64'h0, 64'h8000000, 26'h2000000, 1'b1, 1'b0);
    send_const(64'h8000000, 64'h0, 26'h2000000, 1'b0, 1'b0);
    send_const(64'h8000004, 64'h0, 26'h1FFFFFF, 1'b1, 1'b0);
    send_const(64'hFFFFFFFFFFFFFFF0, 64'h10, 26'h0000008, 1'b0, 1'b0);
    send_const(64'h100, 64'h106, 26'h0000001, 1'b0, ALIGN);
    send_const(64'h0, 64'h8000002, 26'h2000000, 1'b1, ALIGN);
    drain();

    // ---- backpressure: 4 back-to-back offers, out_ready low for 5 cycles ----
    out_ready = 1'b0;
    idx       = 0;
    n_acc     = 0;
    in_valid  = 1'b1;
    pc        = 64'h0;
    target    = 64'h40;
    for (int c = 0; c < 5; c++) begin
      cycle(acc);
      if (acc) begin
        n_acc++;
        idx++;
        pc     = 64'(idx) * 64'h100;
        target = pc + 64'(idx + 1) * 64'h40;
      end
    end
    chk("bp_accepts", 64'(n_acc), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 50 && idx < 4; c++) begin
      cycle(acc);
      if (acc) begin
        idx++;
        pc     = 64'(idx) * 64'h100;
        target = pc + 64'(idx + 1) * 64'h40;
      end
    end
    in_valid = 1'b0;
    chk("bp_all_sent", 64'(idx), 64'd4);
    drain();

    // ---- random traffic against the model ----
    acc = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || acc) begin
        longint off;
        in_valid = ($urandom_range(0, 3) != 0);
        pc       = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) begin
          target = {$urandom, $urandom};
        end else begin
          off    = longint'($urandom_range(0, 32'h3FFFFFFF)) - longint'(32'h20000000);
          target = pc + 64'(off);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(acc);
    end
    drain();

    // ---- reset mid-stream with 2 requests in flight ----
    out_ready = 1'b0;
    send(64'h3000, 64'h3100);
    send(64'h4000, 64'h3F00);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_imm", 64'(imm), 64'd0);
    chk("midrst_oor", 64'(out_of_range), 64'd0);
    chk("midrst_mis", 64'(misaligned), 64'd0);
    exp_q.delete();
    // Offer a request during reset. It must not be taken.
    in_valid  = 1'b1;
    pc        = 64'h5000;
    target    = 64'h5040;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("inrst_out_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_in_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 4; c++) begin
      cycle(acc);
      chk("no_stale_result", 64'(out_valid), 64'd0);
    end

    // ---- pipeline still works after reset ----
    send(64'h10, 64'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
